mdu_div_iter: RTL and testbench

- Iterative 32-bit radix-2 restoring divider for the MIPS DIV/DIVU instructions.
- Sits in the execute/memory region, directly upstream of the MEM->WB pipeline register.
- Its div_hi/div_low/div_complete outputs feed that register's HI/LO capture path. On completion, HI takes the remainder and LO takes the quotient.
- Takes one operand pair per request, runs one quotient bit per cycle, and pulses completion once.

---
 rtl/mdu_div_iter_if.sv | 28 ++
 rtl/mdu_div_iter.sv | 143 ++++++++++++++
 tb/tb_mdu_div_iter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mdu_div_iter_if.sv
// mdu_div_iter_if: request/result bundle between the execute stage and the
// iterative divider.
//   master: div_valid, div_signed, dividend, divisor, cancel (drives)
//   slave : div_ready, div_busy, div_complete, div_hi, div_low (drives)
interface mdu_div_iter_if #(
  parameter int WIDTH = 32
);
  logic             div_valid;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             div_ready;
  logic             div_busy;
  logic             div_complete;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_low;

  modport master (
    output div_valid, div_signed, dividend, divisor, cancel,
    input  div_ready, div_busy, div_complete, div_hi, div_low
  );

  modport slave (
    input  div_valid, div_signed, dividend, divisor, cancel,
    output div_ready, div_busy, div_complete, div_hi, div_low
  );
endinterface

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle; HI = remainder, LO = quotient, held until the
// next completed divide.
// Ports:
//   clock - system clock (posedge)
//   reset - synchronous active-high reset
//   bus   - mdu_div_iter_if.slave (request, cancel, ready/busy/complete, HI/LO)
// Optional build macro: DIV_ZERO_FAST_EN - divisor==0 completes in one cycle.
module mdu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  mdu_div_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    accept = bus.div_valid & ready_q & ~bus.cancel;

    // Invariant rem < divisor keeps |trial| below 2^WIDTH, so bit WIDTH is the sign.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          if (bus.divisor == '0) begin
            state_d = DONE;
            hi_d    = bus.dividend;
            lo_d    = (bus.div_signed & bus.dividend[WIDTH-1]) ? WIDTH'(1) : '1;
          end else
`endif
          begin
            state_d   = BUSY;
            quo_d     = (bus.div_signed & bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
            dsr_d     = (bus.div_signed & bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
            neg_quo_d = bus.div_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_rem_d = bus.div_signed & bus.dividend[WIDTH-1];
            rem_d     = '0;
            cnt_d     = '0;
          end
        end
      end
      BUSY: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          lo_d    = neg_quo_q ? -quo_next : quo_next;
          hi_d    = neg_rem_q ? -rem_next : rem_next;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Cancel overrides everything above, including the final HI/LO update.
    if (bus.cancel) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.div_ready    = ready_q;
  assign bus.div_busy     = busy_q;
  assign bus.div_complete = done_q;
  assign bus.div_hi       = hi_q;
  assign bus.div_low      = lo_q;

endmodule

// File: tb/tb_mdu_div_iter.sv
module tb_mdu_div_iter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  mdu_div_iter_if #(.WIDTH(32)) bus ();

  mdu_div_iter #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at the next negedge, accept on the following posedge (E0),
  // then count negedges until div_complete; latency 33 means complete after E32.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, ".ready_pre"}, 32'(bus.div_ready), 32'd1);
    bus.div_valid  = 1'b1;
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    @(negedge clk);
    bus.div_valid = 1'b0;
    lat = 1;
    check({tag, ".ready_busy"}, {30'd0, bus.div_ready, bus.div_busy}, 32'd1);
    while (!bus.div_complete && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".lo"}, bus.div_low, exp_q);
    check({tag, ".hi"}, bus.div_hi, exp_r);
    @(negedge clk);
    check({tag, ".post_ready_complete"}, {30'd0, bus.div_ready, bus.div_complete}, 32'd2);
    check({tag, ".lo_hold"}, bus.div_low, exp_q);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.div_valid  = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.cancel     = 1'b0;

    repeat (2) @(negedge clk);
    check("reset.ready", 32'(bus.div_ready), 32'd1);
    check("reset.busy", 32'(bus.div_busy), 32'd0);
    check("reset.complete", 32'(bus.div_complete), 32'd0);
    check("reset.hi", bus.div_hi, 32'd0);
    check("reset.lo", bus.div_low, 32'd0);
    rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    run_div("divu_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

    // Cancel at iteration 10: prior result (0 / 0x80000000) must survive.
    @(negedge clk);
    bus.div_valid  = 1'b1;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd50;
    bus.divisor    = 32'd5;
    @(negedge clk);
    bus.div_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("cancel.busy_before", 32'(bus.div_busy), 32'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel.ready", 32'(bus.div_ready), 32'd1);
    check("cancel.busy", 32'(bus.div_busy), 32'd0);
    check("cancel.complete", 32'(bus.div_complete), 32'd0);
    check("cancel.lo", bus.div_low, 32'd0);
    check("cancel.hi", bus.div_hi, 32'h8000_0000);
    repeat (30) @(negedge clk);
    check("cancel.no_late_complete", 32'(bus.div_complete), 32'd0);

    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Cancel in IDLE blocks the accept.
    @(negedge clk);
    bus.div_valid = 1'b1;
    bus.cancel    = 1'b1;
    bus.dividend  = 32'd20;
    bus.divisor   = 32'd4;
    @(negedge clk);
    bus.div_valid = 1'b0;
    bus.cancel    = 1'b0;
    check("idle_cancel.ready", 32'(bus.div_ready), 32'd1);
    check("idle_cancel.busy", 32'(bus.div_busy), 32'd0);

    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, ZERO_LAT);
    run_div("divu_x_0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, ZERO_LAT);
    run_div("div_p_0", 1'b1, 32'd77, 32'd0, 32'hFFFF_FFFF, 32'd77, ZERO_LAT);

    // Reset mid-BUSY.
    @(negedge clk);
    bus.div_valid  = 1'b1;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    @(negedge clk);
    bus.div_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.ready", 32'(bus.div_ready), 32'd1);
    check("rst_mid.busy", 32'(bus.div_busy), 32'd0);
    check("rst_mid.complete", 32'(bus.div_complete), 32'd0);
    check("rst_mid.hi", bus.div_hi, 32'd0);
    check("rst_mid.lo", bus.div_low, 32'd0);
    rst = 1'b0;
    repeat (35) @(negedge clk);
    check("rst_mid.no_late_complete", 32'(bus.div_complete), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
